// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
//   Shared constants and state encodings for the UART command receiver.
//   The host sends fixed 4-byte frames: HDR_BYTE, CMD, DATA, SUM where
//   SUM = CMD ^ DATA. Commands update the run-time configuration that feeds
//   the AD7606 driver and the UART transmitter.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    // Frame delimiter and command codes
    localparam logic [7:0] HDR_BYTE     = 8'hAA;
    localparam logic [7:0] CMD_SET_OS   = 8'h01;
    localparam logic [7:0] CMD_SET_MASK = 8'h02;
    localparam logic [7:0] CMD_STREAM   = 8'h03;

    // Largest oversampling code the AD7606 accepts (x64)
    localparam logic [2:0] OS_MAX = 3'd6;

    // Configuration values after reset: no oversampling, all channels, streaming
    localparam logic [2:0] OS_RST     = 3'b000;
    localparam logic [7:0] MASK_RST   = 8'hFF;
    localparam logic       STREAM_RST = 1'b1;

    // Frame parser: state names are the byte position expected next
    typedef enum logic [1:0] {
        P_HDR = 2'd0,
        P_CMD = 2'd1,
        P_DAT = 2'd2,
        P_SUM = 2'd3
    } p_state_t;

    // Byte receiver
    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } b_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART byte receiver. The asynchronous rx line is synchronised through
//   two flops; a falling edge on the synchronised line starts a byte. The
//   start bit is re-checked at mid-bit to reject glitches, then data bits are
//   sampled every BAUD_DIV cycles LSB first, then the stop bit.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous UART line, idles high
//   byte_vld   out  one-cycle pulse, byte_data holds a good byte
//   byte_data  out  received byte (valid while byte_vld is high)
//   frame_err  out  one-cycle pulse, stop bit sampled low, byte dropped
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    logic          rx_meta;
    logic          rx_s;
    logic          rx_s_d;
    logic          rx_fall;

    b_state_t      b_state;
    b_state_t      b_state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_cnt_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nxt;
    logic          shift_en;

    // ---- stage: rx synchroniser and edge detect ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign rx_fall = rx_s_d & ~rx_s;

    // ---- stage: byte FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state  <= B_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            b_state  <= b_state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
        end
    end

    always_comb begin
        b_state_nxt  = b_state;
        baud_cnt_nxt = baud_cnt + CW'(1);
        bit_cnt_nxt  = bit_cnt;
        shift_en     = 1'b0;
        byte_vld     = 1'b0;
        frame_err    = 1'b0;
        case (b_state)
            B_IDLE: begin
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (rx_fall) begin
                    b_state_nxt = B_START;
                end
            end
            B_START: begin
                // Mid-bit re-check: a line already back high was only a glitch
                if (baud_cnt == HALF_M1) begin
                    baud_cnt_nxt = '0;
                    b_state_nxt  = rx_s ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_nxt = '0;
                    shift_en     = 1'b1;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        b_state_nxt = B_STOP;
                    end
                end
            end
            B_STOP: begin
                // Leave at mid stop bit so a start bit straight after is caught
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_nxt = '0;
                    b_state_nxt  = B_IDLE;
                    byte_vld     = rx_s;
                    frame_err    = ~rx_s;
                end
            end
            default: begin
                b_state_nxt = B_IDLE;
            end
        endcase
    end

    // ---- stage: data shift register, LSB arrives first ----
    always_ff @(posedge clk) begin
        if (shift_en) begin
            byte_data <= {rx_s, byte_data[7:1]};
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
//   Host command receiver. Bytes from uart_rx_byte are assembled into
//   4-byte frames (0xAA, CMD, DATA, SUM). A frame with a matching checksum
//   and a legal command/data pair updates one configuration register and
//   pulses cmd_ok in the same cycle the register changes; any other
//   complete frame pulses cmd_err and leaves the configuration alone.
//   A partial frame is dropped on a framing error or after TIMEOUT_CYC idle
//   cycles.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   rx             in   asynchronous UART line, idles high
//   cfg_os         out  AD7606 oversampling select
//   cfg_ch_mask    out  channel report enable, bit n enables ch(n+1)
//   cfg_stream_en  out  UART reporting enable
//   cmd_ok         out  one-cycle pulse, valid frame applied
//   cmd_err        out  one-cycle pulse, frame rejected
//   frame_err      out  one-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int TIMEOUT_CYC = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [2:0] cfg_os,
    output logic [7:0] cfg_ch_mask,
    output logic       cfg_stream_en,
    output logic       cmd_ok,
    output logic       cmd_err,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    logic            vld_p0;
    logic [7:0]      byte_p0;
    logic            ferr_p0;

    p_state_t        p_state;
    p_state_t        p_state_nxt;
    logic [7:0]      cmd_byte;
    logic [7:0]      dat_byte;
    logic            sum_ok;
    logic            cmd_legal;
    logic            ok_p0;
    logic            err_p0;

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Idle counter increment that holds at TO_MAX instead of wrapping
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_W'(1);
    endfunction

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_vld  (vld_p0),
        .byte_data (byte_p0),
        .frame_err (ferr_p0)
    );

    assign frame_err = ferr_p0;

    // ---- stage p0: frame parser on received bytes ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_HDR;
        end else begin
            p_state <= p_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0 && (p_state == P_CMD)) begin
            cmd_byte <= byte_p0;
        end
        if (vld_p0 && (p_state == P_DAT)) begin
            dat_byte <= byte_p0;
        end
    end

    // The SUM byte is checked straight off the receiver, so the verdict is
    // ready in the same cycle as its byte valid.
    always_comb begin
        sum_ok    = (byte_p0 == (cmd_byte ^ dat_byte));
        cmd_legal = 1'b0;
        case (cmd_byte)
            CMD_SET_OS:   cmd_legal = (dat_byte <= {5'd0, OS_MAX});
            CMD_SET_MASK: cmd_legal = 1'b1;
            CMD_STREAM:   cmd_legal = 1'b1;
            default:      cmd_legal = 1'b0;
        endcase
    end

    always_comb begin
        p_state_nxt = p_state;
        ok_p0       = 1'b0;
        err_p0      = 1'b0;
        if (vld_p0) begin
            // A byte always beats a coincident timeout
            case (p_state)
                P_HDR: begin
                    if (byte_p0 == HDR_BYTE) begin
                        p_state_nxt = P_CMD;
                    end
                end
                P_CMD: p_state_nxt = P_DAT;
                P_DAT: p_state_nxt = P_SUM;
                P_SUM: begin
                    p_state_nxt = P_HDR;
                    ok_p0       = sum_ok & cmd_legal;
                    err_p0      = ~(sum_ok & cmd_legal);
                end
                default: p_state_nxt = P_HDR;
            endcase
        end else if ((p_state != P_HDR) && (ferr_p0 || to_hit)) begin
            p_state_nxt = P_HDR;
        end
    end

    // ---- stage p0: partial-frame idle timeout ----
    assign to_hit = (to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if ((p_state == P_HDR) || vld_p0) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= sat_inc(to_cnt);
        end
    end

    // ---- stage p1: result pulses and configuration registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ok        <= 1'b0;
            cmd_err       <= 1'b0;
            cfg_os        <= OS_RST;
            cfg_ch_mask   <= MASK_RST;
            cfg_stream_en <= STREAM_RST;
        end else begin
            cmd_ok  <= ok_p0;
            cmd_err <= err_p0;
            if (ok_p0) begin
                case (cmd_byte)
                    CMD_SET_OS:   cfg_os        <= dat_byte[2:0];
                    CMD_SET_MASK: cfg_ch_mask   <= dat_byte;
                    CMD_STREAM:   cfg_stream_en <= dat_byte[0];
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
//   Drives UART frames into uart_cmd_rx and compares every cycle against a
//   byte-level model of the command protocol. Clock and baud are scaled so
//   one bit lasts 16 clocks; the timeout is shortened to keep runs short.
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;

    localparam int CLK_FREQ    = 1_843_200;
    localparam int BAUD        = 115_200;
    localparam int TIMEOUT_CYC = 2000;
    localparam int BAUD_DIV    = CLK_FREQ / BAUD;
    // Cycle of the stop-bit sample, counted from the cycle the start bit is
    // driven: 2 sync flops + edge detect, half a bit, 8 data bits, stop bit.
    localparam int STOP_LAT    = 3 + BAUD_DIV / 2 + 9 * BAUD_DIV - 1;

    typedef struct {
        int         t;
        bit         ok;
        logic [2:0] os;
        logic [7:0] mask;
        logic       st;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [2:0] cfg_os;
    logic [7:0] cfg_ch_mask;
    logic       cfg_stream_en;
    logic       cmd_ok;
    logic       cmd_err;
    logic       frame_err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    // protocol model
    int         pos;
    logic [7:0] m_cmd, m_dat;
    logic [2:0] fut_os;
    logic [7:0] fut_mask;
    logic       fut_st;
    logic [2:0] cur_os;
    logic [7:0] cur_mask;
    logic       cur_st;
    int         last_v;
    ev_t        ev_q[$];
    int         fe_q[$];

    int ok_cnt = 0, err_cnt = 0, fe_cnt = 0;
    int last_ok_cyc = 0;
    int last_t0 = 0;

    uart_cmd_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .cfg_os        (cfg_os),
        .cfg_ch_mask   (cfg_ch_mask),
        .cfg_stream_en (cfg_stream_en),
        .cmd_ok        (cmd_ok),
        .cmd_err       (cmd_err),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pos      = 0;
        last_v   = 0;
        fut_os   = 3'd0;
        fut_mask = 8'hFF;
        fut_st   = 1'b1;
        cur_os   = 3'd0;
        cur_mask = 8'hFF;
        cur_st   = 1'b1;
        ev_q.delete();
        fe_q.delete();
    endtask

    // Byte-position model of the frame protocol
    task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int t0);
        int  tv;
        bit  good;
        ev_t ev;
        tv = t0 + STOP_LAT;
        if (!stop_ok) begin
            fe_q.push_back(tv);
            pos = 0;
            return;
        end
        if (pos != 0 && (tv - last_v) > TIMEOUT_CYC) pos = 0;
        last_v = tv;
        case (pos)
            0: if (b == 8'hAA) pos = 1;
            1: begin m_cmd = b; pos = 2; end
            2: begin m_dat = b; pos = 3; end
            default: begin
                pos  = 0;
                good = (b == (m_cmd ^ m_dat));
                if (good) begin
                    case (m_cmd)
                        8'h01: if (m_dat <= 8'd6) fut_os = m_dat[2:0]; else good = 1'b0;
                        8'h02: fut_mask = m_dat;
                        8'h03: fut_st = m_dat[0];
                        default: good = 1'b0;
                    endcase
                end
                ev.t    = tv + 1;
                ev.ok   = good;
                ev.os   = fut_os;
                ev.mask = fut_mask;
                ev.st   = fut_st;
                ev_q.push_back(ev);
            end
        endcase
    endtask

    // All driving happens 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr      = {stop_ok, b, 1'b0};
        last_t0 = cyc;
        model_byte(b, stop_ok, cyc);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (BAUD_DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
        send_byte(8'hAA, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
        send_byte(s, 1'b1);
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        idle(len);
        rx = 1'b1;
        idle(24);
    endtask

    task automatic monitor();
        ev_t        ev;
        logic [14:0] act_v, exp_v;
        logic       e_ok, e_err, e_fe;
        forever begin
            @(negedge clk);
            e_ok  = 1'b0;
            e_err = 1'b0;
            e_fe  = 1'b0;
            if (ev_q.size() != 0 && ev_q[0].t == cyc) begin
                ev = ev_q[0];
                ev_q.delete(0);
                e_ok     = ev.ok;
                e_err    = !ev.ok;
                cur_os   = ev.os;
                cur_mask = ev.mask;
                cur_st   = ev.st;
            end
            if (fe_q.size() != 0 && fe_q[0] == cyc) begin
                fe_q.delete(0);
                e_fe = 1'b1;
            end
            if (cmd_ok === 1'b1) begin
                ok_cnt++;
                last_ok_cyc = cyc;
            end
            if (cmd_err === 1'b1) err_cnt++;
            if (frame_err === 1'b1) fe_cnt++;
            act_v = {cmd_ok, cmd_err, frame_err, cfg_os, cfg_ch_mask, cfg_stream_en};
            exp_v = {e_ok, e_err, e_fe, cur_os, cur_mask, cur_st};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                if (fail_prints < 30) begin
                    fail_prints++;
                    $display("FAIL cycle %0d outputs ok,err,fe,os,mask,stream got %b,%b,%b,%0d,%02h,%b expected %b,%b,%b,%0d,%02h,%b",
                             cyc, cmd_ok, cmd_err, frame_err, cfg_os, cfg_ch_mask, cfg_stream_en,
                             e_ok, e_err, e_fe, cur_os, cur_mask, cur_st);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] c, d, s;
        int         sel;

        rst_n = 1'b0;
        rx    = 1'b1;
        model_reset();
        fork
            monitor();
            begin
                repeat (95000) @(posedge clk);
                $display("FAIL watchdog: got %0d cycles, limit 95000", cyc);
                $fatal(1, "cycle limit");
            end
        join_none

        idle(3);
        rst_n = 1'b1;

        // Reset state, then a long idle line
        idle(10000);
        check("reset_os", int'(cfg_os), 0);
        check("reset_mask", int'(cfg_ch_mask), 255);
        check("reset_stream", int'(cfg_stream_en), 1);
        check("reset_pulses", ok_cnt + err_cnt + fe_cnt, 0);

        // Set oversampling
        send_frame(8'h01, 8'h04, 8'h05);
        idle(5);
        check("os4_value", int'(cfg_os), 4);
        check("os4_mask", int'(cfg_ch_mask), 255);
        check("os4_ok_count", ok_cnt, 1);
        check("ok_latency", last_ok_cyc - last_t0, 155);

        // Two frames back to back
        send_frame(8'h02, 8'h0F, 8'h0D);
        send_frame(8'h03, 8'h00, 8'h03);
        idle(5);
        check("b2b_ok_count", ok_cnt, 3);
        check("b2b_mask", int'(cfg_ch_mask), 8'h0F);
        check("b2b_stream", int'(cfg_stream_en), 0);

        // Rejected frames
        send_frame(8'h01, 8'h07, 8'h06);
        idle(10);
        send_frame(8'h02, 8'h0F, 8'h00);
        idle(10);
        send_frame(8'h09, 8'h00, 8'h09);
        idle(5);
        check("rej_err_count", err_cnt, 3);
        check("rej_ok_count", ok_cnt, 3);
        check("rej_os", int'(cfg_os), 4);
        check("rej_mask", int'(cfg_ch_mask), 8'h0F);

        // Short glitch, then a byte with a low stop bit, then a good frame
        glitch(4);
        check("glitch_pulses", ok_cnt + err_cnt + fe_cnt, 6);
        send_byte(8'h55, 1'b0);
        idle(24);
        check("ferr_count", fe_cnt, 1);
        send_frame(8'h01, 8'h02, 8'h03);
        idle(5);
        check("after_ferr_os", int'(cfg_os), 2);
        check("after_ferr_ok", ok_cnt, 4);

        // Partial frame abandoned by the idle timeout
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(3 * TIMEOUT_CYC);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle(5);
        check("timeout_ok", ok_cnt, 4);
        check("timeout_err", err_cnt, 3);
        check("timeout_os", int'(cfg_os), 2);

        // Reset in the middle of a data byte, mid-frame
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        idle(40);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_os", int'(cfg_os), 0);
        check("rst_mid_mask", int'(cfg_ch_mask), 255);
        check("rst_mid_stream", int'(cfg_stream_en), 1);
        rx = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(20);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        idle(5);
        check("rst_discard_ok", ok_cnt, 4);
        check("rst_discard_os", int'(cfg_os), 0);

        // Randomised frames with stray bytes, framing errors and glitches
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                send_byte(8'($urandom), 1'b1);
                idle($urandom_range(0, 20));
            end
            sel = $urandom_range(0, 3);
            c   = (sel == 3) ? 8'($urandom) : 8'(sel + 1);
            d   = (c == 8'h01) ? 8'($urandom_range(0, 8)) : 8'($urandom);
            s   = c ^ d;
            if ($urandom_range(0, 6) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            send_byte(8'hAA, 1'b1);
            idle($urandom_range(0, 20));
            send_byte(c, 1'b1);
            if ($urandom_range(0, 9) == 0) begin
                send_byte(8'($urandom), 1'b0);
                idle(24);
            end
            if ($urandom_range(0, 9) == 0) glitch($urandom_range(1, 5));
            send_byte(d, 1'b1);
            idle($urandom_range(0, 20));
            send_byte(s, 1'b1);
            idle($urandom_range(0, 30));
        end

        idle(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Receive-side counterpart to the existing UART transmit path.
- Deserialises the board `rx` line at 8N1.
- Parses fixed 4-byte command frames from the host.
- Drives run-time configuration registers: AD7606 oversampling select, per-channel report mask, stream enable. These feed the ad7606 driver and the UART transmitter at top level.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate; BAUD_DIV = CLK_FREQ/BAUD (434 at the defaults).
- TIMEOUT_CYC, 500_000, idle cycles (10 ms) after which a partial frame is discarded.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous UART line; idles high.
- cfg_os  out  3  AD7606 oversampling select.
- cfg_ch_mask  out  8  channel report enable; bit n enables ch(n+1).
- cfg_stream_en  out  1  UART reporting enable.
- cmd_ok  out  1  one-cycle pulse: valid frame applied.
- cmd_err  out  1  one-cycle pulse: frame rejected (checksum, unknown command, or illegal data).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (asynchronous, active-low):
  - cfg_os=3'b000, cfg_ch_mask=8'hFF, cfg_stream_en=1.
  - cmd_ok, cmd_err and frame_err are 0.
  - rx synchroniser flops are 1.
  - Both state machines go to their idle states.
  - Reset asserted mid-byte or mid-frame discards all partial data.
- Synchroniser: rx passes through 2 flops (rx_s) before any use. A falling edge is detected on rx_s.
- Byte receiver FSM, states B_IDLE, B_START, B_DATA, B_STOP:
  - B_IDLE: on rx_s falling edge, clear the bit counter and go to B_START.
  - B_START: after BAUD_DIV/2 cycles, sample rx_s.
    - Low: go to B_DATA.
    - High: false start, return to B_IDLE with no output.
  - B_DATA: sample every BAUD_DIV cycles, LSB first, 8 samples, then go to B_STOP.
  - B_STOP: sample after BAUD_DIV cycles.
    - High: 1-cycle byte_vld with byte_data.
    - Low: 1-cycle frame_err; byte dropped.
    - Either way, return to B_IDLE the same cycle. This allows back-to-back bytes with a single stop bit.
- Frame format: 0xAA, CMD, DATA, SUM, where SUM = CMD ^ DATA.
- Parser FSM, states P_HDR, P_CMD, P_DAT, P_SUM; each advances on byte_vld.
  - P_HDR: only 0xAA advances; any other byte is ignored.
  - Positions are strict: 0xAA received in P_CMD/P_DAT/P_SUM is taken as data, with no resync.
  - SUM received: go to P_HDR and evaluate the frame. The result registers in the cycle after the SUM byte_vld (latency 1 clk); the cmd_ok/cmd_err pulse is coincident with the config update.
- Commands:
  - CMD 0x01: cfg_os <= DATA[2:0]. Rejected if DATA > 6.
  - CMD 0x02: cfg_ch_mask <= DATA.
  - CMD 0x03: cfg_stream_en <= DATA[0]. DATA[7:1] is ignored.
  - Any other CMD: cmd_err.
  - Checksum mismatch: cmd_err; config unchanged.
  - A rejected frame never alters any cfg_* output.
- frame_err while the parser is not in P_HDR: parser returns to P_HDR; no cmd_err.
- Timeout:
  - The idle counter clears on every byte_vld.
  - It counts while the parser is not in P_HDR.
  - At TIMEOUT_CYC the parser returns to P_HDR silently; the counter saturates and is held clear in P_HDR.
- Simultaneous events:
  - byte_vld and timeout in the same cycle: byte_vld wins and the counter clears.
  - cmd_ok and cmd_err are mutually exclusive.
- Counter widths: baud counter is clog2(BAUD_DIV); timeout counter is clog2(TIMEOUT_CYC+1).

Decomposition:
- Package uart_cmd_pkg holds:
  - HDR_BYTE=8'hAA.
  - CMD_SET_OS=8'h01, CMD_SET_MASK=8'h02, CMD_STREAM=8'h03.
  - OS_MAX=3'd6.
  - The parser state encodings.
- Sub-module uart_rx_byte (CLK_FREQ, BAUD): sync + byte FSM, outputs byte_vld, byte_data, frame_err.
- uart_cmd_rx instantiates uart_rx_byte and adds the parser, checksum, config registers and timeout counter.

Test Plan:
- Reset, then idle rx=1 for 10 000 cycles → cfg_os=0, cfg_ch_mask=FF, cfg_stream_en=1; no pulses.
- Send AA 01 04 05 at 115200 → one cmd_ok, 1 clk after the SUM stop-bit sample; cfg_os=4; mask and stream unchanged.
- Send AA 02 0F 0D, then AA 03 00 03 back-to-back with no gap → two cmd_ok; cfg_ch_mask=0F, cfg_stream_en=0.
- Send each of: AA 01 07 06 (illegal os), AA 02 0F 00 (bad sum), AA 09 00 09 (unknown cmd) → one cmd_err per frame; all cfg_* unchanged.
- 100-cycle low glitch on rx → no byte, no pulses. Separately, a byte with stop bit forced low → frame_err. Then send AA 01 02 03 → parser is in P_HDR; cmd_ok, cfg_os=2.
- Timeout and reset:
  - Send AA 01, idle 600 000 cycles, then 02 03 → no cmd_ok, cfg_os unchanged.
  - Assert rst_n low mid-DATA byte → outputs return to reset values immediately.
